// File: rtl/dm_pkg.sv
// Shared frame geometry, FSM state type and row pack/unpack helpers for the
// dot-matrix frame controller.
package dm_pkg;

  localparam int unsigned DM_ROWS    = 8;
  localparam int unsigned DM_COLS    = 8;
  localparam int unsigned DM_FRAME_W = DM_ROWS * DM_COLS;
  localparam int unsigned DM_ROW_W   = $clog2(DM_ROWS);

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_PEND
  } dm_state_e;

  // Extract row r from a packed frame (row r lives at bits [8r+7:8r]).
  function automatic logic [DM_COLS-1:0] dm_row_get(input logic [DM_FRAME_W-1:0] frame,
                                                    input logic [DM_ROW_W-1:0]   row);
    return frame[int'(row) * DM_COLS +: DM_COLS];
  endfunction

  // Return a copy of the frame with row r replaced.
  function automatic logic [DM_FRAME_W-1:0] dm_row_put(input logic [DM_FRAME_W-1:0] frame,
                                                       input logic [DM_ROW_W-1:0]   row,
                                                       input logic [DM_COLS-1:0]    data);
    logic [DM_FRAME_W-1:0] f;
    f = frame;
    f[int'(row) * DM_COLS +: DM_COLS] = data;
    return f;
  endfunction

  // One-column scroll step: column 7 wraps around to column 0.
  function automatic logic [DM_COLS-1:0] dm_row_rotl(input logic [DM_COLS-1:0] row);
    return {row[DM_COLS-2:0], row[DM_COLS-1]};
  endfunction

endpackage

// File: rtl/dm_frame_buf.sv
// 8x8 frame register with a row write port, a full-frame parallel load and a
// rotate-by-one-column command. Load takes priority over rotate and write.
module dm_frame_buf
  import dm_pkg::*;
(
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  input  logic                  i_WrEn,
  input  logic [DM_ROW_W-1:0]   i_WrRow,
  input  logic [DM_COLS-1:0]    i_WrData,
  input  logic                  i_Load,
  input  logic [DM_FRAME_W-1:0] i_LoadData,
  input  logic                  i_Rot,
  output logic [DM_FRAME_W-1:0] o_Data
);

  logic [DM_FRAME_W-1:0] frame_q;
  logic [DM_FRAME_W-1:0] frame_d;

  // Next-state frame: load overrides; otherwise rotate all rows, then apply a row write.
  always_comb begin
    frame_d = frame_q;
    if (i_Load) begin
      frame_d = i_LoadData;
    end else begin
      if (i_Rot) begin
        for (int unsigned r = 0; r < DM_ROWS; r++) begin
          frame_d = dm_row_put(frame_d, DM_ROW_W'(r),
                               dm_row_rotl(dm_row_get(frame_d, DM_ROW_W'(r))));
        end
      end
      if (i_WrEn) begin
        frame_d = dm_row_put(frame_d, i_WrRow, i_WrData);
      end
    end
  end

  // Frame storage with synchronous clear.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      frame_q <= '0;
    end else begin
      frame_q <= frame_d;
    end
  end

  assign o_Data = frame_q;

endmodule

// File: rtl/dm_frame_ctrl.sv
// Double-buffered frame controller for the 8x8 dot-matrix scanner. The host
// fills the back buffer and commits; the swap to the front buffer happens only
// on the scanner's end-of-frame pulse so a scan never shows a torn image. The
// front frame optionally scrolls one column every i_Hold complete scans.
module dm_frame_ctrl
  import dm_pkg::*;
#(
  parameter int unsigned P_HOLD_W = 8
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  input  logic                  i_fDone,
  input  logic                  i_WrEn,
  input  logic [2:0]            i_WrRow,
  input  logic [7:0]            i_WrData,
  input  logic                  i_Commit,
  input  logic                  i_Scroll,
  input  logic [P_HOLD_W-1:0]   i_Hold,
  output logic [DM_FRAME_W-1:0] o_Data,
  output logic                  o_Busy,
  output logic                  o_fSwap
);

  localparam logic [P_HOLD_W-1:0] HoldOne = P_HOLD_W'(1);

  dm_state_e             state_q;
  logic                  fswap_q;
  logic [P_HOLD_W-1:0]   hold_q;
  logic [DM_FRAME_W-1:0] back_data;

  logic back_wr;
  logic swap;
  logic scroll_en;
  logic step_due;
  logic step;

  assign back_wr   = i_WrEn && (state_q == ST_IDLE);
  assign swap      = (state_q == ST_PEND) && i_fDone;
  assign scroll_en = i_Scroll && (i_Hold != '0);
  // >= rather than == so that lowering i_Hold mid-count still yields a step.
  assign step_due  = hold_q >= (i_Hold - HoldOne);
  // A swap on the same frame boundary wins: the new frame loads unrotated.
  assign step      = i_fDone && scroll_en && step_due && !swap;

  dm_frame_buf u_back (
    .i_Clk      (i_Clk),
    .i_Rst      (i_Rst),
    .i_WrEn     (back_wr),
    .i_WrRow    (i_WrRow),
    .i_WrData   (i_WrData),
    .i_Load     (1'b0),
    .i_LoadData ('0),
    .i_Rot      (1'b0),
    .o_Data     (back_data)
  );

  dm_frame_buf u_front (
    .i_Clk      (i_Clk),
    .i_Rst      (i_Rst),
    .i_WrEn     (1'b0),
    .i_WrRow    ('0),
    .i_WrData   ('0),
    .i_Load     (swap),
    .i_LoadData (back_data),
    .i_Rot      (step),
    .o_Data     (o_Data)
  );

  // Commit FSM: IDLE accepts a commit, PEND waits for the frame boundary to swap.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q <= ST_IDLE;
      fswap_q <= 1'b0;
    end else begin
      fswap_q <= swap;
      unique case (state_q)
        ST_IDLE: if (i_Commit) state_q <= ST_PEND;
        ST_PEND: if (i_fDone)  state_q <= ST_IDLE;
        default:               state_q <= ST_IDLE;
      endcase
    end
  end

  // Scroll hold counter: counts completed scans, clears on a step, a swap or when disabled.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      hold_q <= '0;
    end else if (swap || !scroll_en) begin
      hold_q <= '0;
    end else if (i_fDone) begin
      if (step_due) begin
        hold_q <= '0;
      end else begin
        hold_q <= hold_q + HoldOne;
      end
    end
  end

  assign o_Busy  = (state_q == ST_PEND);
  assign o_fSwap = fswap_q;

endmodule

// File: tb/tb_dm_frame_ctrl.sv
// Scoreboard bench for dm_frame_ctrl: stimulus pushes the expected frame for
// every swap or scroll step; a monitor pops and compares whenever o_Data
// changes or o_fSwap pulses.
module tb_dm_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        fdone;
  logic        wr_en;
  logic [2:0]  wr_row;
  logic [7:0]  wr_data;
  logic        commit;
  logic        scroll;
  logic [7:0]  hold;
  logic [63:0] data;
  logic        busy;
  logic        fswap;

  typedef struct {
    logic [63:0] data;
    logic        swap;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic        mon_en = 1'b0;
  logic [63:0] prev_data;

  dm_frame_ctrl #(.P_HOLD_W(8)) dut (
    .i_Clk    (clk),
    .i_Rst    (rst),
    .i_fDone  (fdone),
    .i_WrEn   (wr_en),
    .i_WrRow  (wr_row),
    .i_WrData (wr_data),
    .i_Commit (commit),
    .i_Scroll (scroll),
    .i_Hold   (hold),
    .o_Data   (data),
    .o_Busy   (busy),
    .o_fSwap  (fswap)
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: any output event must match the head of the scoreboard.
  always @(negedge clk) begin
    if (mon_en && (fswap || data !== prev_data)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event actual data=%h swap=%b required no event", data, fswap);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("event_data", data, e.data);
        check("event_swap", {63'd0, fswap}, {63'd0, e.swap});
      end
    end
    prev_data = data;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] d, input logic s);
    exp_t e;
    e.data = d;
    e.swap = s;
    exp_q.push_back(e);
  endtask

  task automatic write_row(input logic [2:0] r, input logic [7:0] d);
    wr_en = 1'b1; wr_row = r; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pulse_commit();
    commit = 1'b1;
    tick();
    commit = 1'b0;
  endtask

  task automatic pulse_fdone();
    fdone = 1'b1;
    tick();
    fdone = 1'b0;
  endtask

  initial begin
    rst = 1'b1; fdone = 1'b0; wr_en = 1'b0; wr_row = '0; wr_data = '0;
    commit = 1'b0; scroll = 1'b0; hold = '0;
    tick(2);
    rst = 1'b0;
    tick();
    check("reset_data", data, 64'd0);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_fswap", {63'd0, fswap}, 64'd0);
    mon_en = 1'b1;

    // Fill back buffer, commit, swap on the frame boundary.
    for (int r = 0; r < 8; r++) write_row(3'(r), 8'(r + 1));
    pulse_commit();
    check("commit_busy", {63'd0, busy}, 64'd1);
    tick(3);
    check("pend_data_held", data, 64'd0);
    push(64'h0807060504030201, 1'b1);
    pulse_fdone();
    check("swap_busy_low", {63'd0, busy}, 64'd0);
    tick(3);

    // Writes and commits while busy are dropped; exactly one swap follows.
    pulse_commit();
    check("busy_again", {63'd0, busy}, 64'd1);
    write_row(3'd0, 8'hFF);
    pulse_commit();
    tick(2);
    push(64'h0807060504030201, 1'b1);
    pulse_fdone();
    tick(4);
    check("busy_dropped_busy", {63'd0, busy}, 64'd0);

    // Load all-0x81 frame, then scroll every 3 scans.
    for (int r = 0; r < 8; r++) write_row(3'(r), 8'h81);
    pulse_commit();
    push({8{8'h81}}, 1'b1);
    pulse_fdone();
    tick(2);
    scroll = 1'b1;
    hold = 8'd3;
    for (int k = 1; k <= 6; k++) begin
      if (k == 3) push({8{8'h03}}, 1'b0);
      if (k == 6) push({8{8'h06}}, 1'b0);
      pulse_fdone();
      tick(2);
    end
    check("scroll6_data", data, {8{8'h06}});

    // Swap beats a due scroll step; the next boundary rotates once.
    hold = 8'd1;
    for (int r = 0; r < 8; r++) write_row(3'(r), 8'hC0);
    pulse_commit();
    push({8{8'hC0}}, 1'b1);
    pulse_fdone();
    tick(2);
    check("swap_unrotated", data, {8{8'hC0}});
    push({8{8'h81}}, 1'b0);
    pulse_fdone();
    tick(2);

    // Hold of 0 disables scrolling.
    hold = 8'd0;
    for (int k = 0; k < 10; k++) begin
      pulse_fdone();
      tick();
    end
    check("hold0_static", data, {8{8'h81}});

    // Reset while a commit is pending drops it.
    pulse_commit();
    check("pend_before_rst", {63'd0, busy}, 64'd1);
    push(64'd0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_pend_data", data, 64'd0);
    check("rst_pend_busy", {63'd0, busy}, 64'd0);
    tick();
    pulse_fdone();
    tick(4);
    check("rst_no_swap_data", data, 64'd0);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dm_frame_ctrl.md
Name: dm_frame_ctrl

Overview:
- Frame controller that sits in front of the 8x8 dot-matrix row scanner and supplies its 64-bit frame word.
- Holds a double-buffered frame: a host writes the back buffer row by row, then commits it. The block swaps it to the front buffer only at a scan-frame boundary, signalled by the scanner's done pulse, so no scan ever shows a torn image.
- Optionally scrolls the displayed frame horizontally, one column every N complete scans.

Parameters:
- P_HOLD_W, 8, width of the scroll-hold count input (max scans per scroll step = 2^P_HOLD_W - 1)

Ports:
- i_Clk  input  1  system clock, 50 MHz
- i_Rst  input  1  synchronous, active-high reset
- i_fDone  input  1  one-cycle pulse from the scanner at the end of the last row of a full scan
- i_WrEn  input  1  back-buffer row write strobe
- i_WrRow  input  3  back-buffer row index (0..7)
- i_WrData  input  8  row pixel byte; bit c = column c
- i_Commit  input  1  one-cycle request to swap the back buffer to the front at the next scan boundary
- i_Scroll  input  1  1 = scroll mode, 0 = static
- i_Hold  input  P_HOLD_W  full scans per scroll step; 0 disables scrolling
- o_Data  output  64  front frame to the scanner; row r at bits [8r+7:8r]
- o_Busy  output  1  commit pending; back-buffer writes and commits are ignored while high
- o_fSwap  output  1  one-cycle pulse in the cycle after a swap takes effect

Behaviour:
- Reset is synchronous, active-high, and is the only reset.
  - Front buffer, back buffer and o_Data clear to 0.
  - o_Busy=0, o_fSwap=0, hold counter=0, FSM state IDLE.
  - Reset during a pending commit drops the commit.
- Back buffer writes: when i_WrEn=1 and o_Busy=0, row i_WrRow <= i_WrData at the clock edge. When o_Busy=1, writes are dropped silently.
- FSM has two states, IDLE and PEND.
  - IDLE: i_Commit=1 -> PEND, with o_Busy=1 from the next cycle. If i_WrEn and i_Commit arrive in the same cycle, the write lands and is included in the commit.
  - PEND: i_Commit is ignored. On i_fDone=1:
    - front <= back, hold counter <= 0, state -> IDLE.
    - o_Busy falls and o_fSwap=1 in the following cycle.
  - Back buffer contents are preserved after a swap (not cleared).
- Hold counter (P_HOLD_W bits) advances only on i_fDone while i_Scroll=1 and i_Hold!=0.
  - When the counter equals i_Hold-1 and i_fDone=1: counter <= 0 and every front row rotates by one column, row <= {row[6:0],row[7]}. Bit 7 wraps to bit 0.
  - Otherwise the counter increments on i_fDone.
  - A scroll step occurs once every i_Hold scans.
- i_Scroll=0 or i_Hold=0: no rotation and the counter holds at 0.
- Changing i_Hold mid-count:
  - If the counter is already >= the new i_Hold-1, the next i_fDone performs a step and clears the counter.
  - The compare is therefore >=, not ==.
- A swap and a scroll step due on the same i_fDone: the swap wins. The new frame loads unrotated and the counter clears.
- o_Data is driven directly from the front register. It changes exactly one cycle after the i_fDone edge that caused a swap or step, and is stable at all other times.
- No arithmetic wider than P_HOLD_W; the counter never wraps because it clears at i_Hold-1.

Decomposition:
- Shared package dm_pkg:
  - frame geometry constants: DM_ROWS=8, DM_COLS=8, DM_FRAME_W=64.
  - FSM state enum {ST_IDLE, ST_PEND}.
  - row pack/unpack helper functions (row r <-> bits [8r+:8]).
- One natural sub-module, dm_frame_buf: an 8x8 register array with a row write port, a 64-bit parallel load, a rotate-by-one command and a 64-bit packed read. Instantiate it twice (front and back; the back buffer's rotate is tied low).
- FSM and hold counter live in the top-level block.

Test Plan:
- Reset, then write rows 0..7 = 8'h01..8'h08 and pulse i_Commit -> o_Busy=1; o_Data stays 0 until i_fDone. One cycle after i_fDone: o_Data=64'h0807060504030201, o_fSwap=1 for one cycle, o_Busy=0.
- While o_Busy=1, write row 0 = 8'hFF and pulse i_Commit again -> after the swap, row 0 = 8'h01 and only one o_fSwap pulse is seen.
- Front rows all 8'h81, i_Scroll=1, i_Hold=3, pulse i_fDone 6 times -> after the 3rd pulse every row is 8'h03; after the 6th, every row is 8'h06.
- i_Hold=1 with a commit pending and i_fDone -> the frame loads unrotated with no step that cycle; the next i_fDone rotates it once.
- i_Scroll=1, i_Hold=0, 10 i_fDone pulses -> o_Data unchanged.
- Assert i_Rst for 1 cycle while in PEND with nonzero front -> next cycle o_Data=0 and o_Busy=0; a later i_fDone produces no o_fSwap.
